// File: rtl/parser_pkg.sv
// Shared constants and types for the message packer/parser pair.
package parser_pkg;

    localparam int MSG_COUNT_LEN  = 2;
    localparam int MSG_LENGTH_LEN = 2;
    localparam int BYTES_PER_BEAT = 8;
    localparam int MAX_MSG_SIZE   = 32;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE,
        PACK,
        DRAIN
    } packer_state_t;

endpackage

// File: rtl/msg_byte_aligner.sv
// Builds the append vector (optional count, length prefix, data) and writes it
// into the staging buffer image starting at byte offset fill.
module msg_byte_aligner
    import parser_pkg::*;
#(
    parameter int BUF_BYTES = 48,
    parameter int MSG_BYTES = 32,
    parameter int FILL_W    = $clog2(BUF_BYTES + 1),
    parameter int LEN_W     = $clog2(MSG_BYTES) + 1
) (
    input  logic [8*BUF_BYTES-1:0] buf_in,
    input  logic [FILL_W-1:0]      fill,
    input  logic                   with_count,
    input  logic [15:0]            count,
    input  logic [LEN_W-1:0]       len,
    input  logic [8*MSG_BYTES-1:0] data,
    output logic [8*BUF_BYTES-1:0] buf_out,
    output logic [FILL_W-1:0]      app_len
);

    localparam int APP_BYTES = MSG_COUNT_LEN + MSG_LENGTH_LEN + MSG_BYTES;

    logic [8*MSG_BYTES-1:0] data_m;
    logic [8*APP_BYTES-1:0] app_vec;
    logic [8*BUF_BYTES-1:0] placed;
    logic [15:0]            len16;
    byte_t                  len_hi;
    byte_t                  len_lo;

    always_comb begin
        len16  = 16'(len);
        len_hi = len16[15:8];
        len_lo = len16[7:0];
        data_m = '0;
        for (int k = 0; k < MSG_BYTES; k++) begin
            if (k < 32'(len)) data_m[8*k+:8] = data[8*k+:8];
        end
        // Lowest byte goes out first, so headers sit in the low bytes, MSB first.
        app_vec = {data_m, len_lo, len_hi, count[7:0], count[15:8]};
        if (!with_count) app_vec = app_vec >> (8 * MSG_COUNT_LEN);
        app_len = FILL_W'(len) + FILL_W'(with_count ? MSG_COUNT_LEN + MSG_LENGTH_LEN
                                                    : MSG_LENGTH_LEN);
        placed  = (8*BUF_BYTES)'(app_vec) << (8 * 32'(fill));
        buf_out = buf_in;
        for (int i = 0; i < BUF_BYTES; i++) begin
            if (i >= 32'(fill)) buf_out[8*i+:8] = placed[8*i+:8];
        end
    end

endmodule

// File: rtl/msg_packer.sv
// Serialises whole messages into a framed 64-bit payload stream (count, then len+data).
// Optional MSG_PACKER_STATS_EN adds stat_frame_bytes, the bytes emitted in the current frame.
module msg_packer
    import parser_pkg::*;
#(
    parameter int OP_DATA_WIDTH = 64,
    parameter int IN_DATA_WIDTH = 256,
    parameter int MAX_MSG_SIZE  = parser_pkg::MAX_MSG_SIZE,
    parameter int BUF_BYTES     = 48
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_sop,
    input  logic [15:0]                     in_count,
    input  logic [$clog2(MAX_MSG_SIZE):0]   in_len,
    input  logic [IN_DATA_WIDTH-1:0]        in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [OP_DATA_WIDTH-1:0]        out_data,
    output logic                            out_startofpayload,
    output logic                            out_endofpayload,
    output logic [2:0]                      out_empty,
    output logic                            out_error
`ifdef MSG_PACKER_STATS_EN
    ,output logic [15:0]                    stat_frame_bytes
`endif
);

    localparam int FILL_W = $clog2(BUF_BYTES + 1);
    localparam int LEN_W  = $clog2(MAX_MSG_SIZE) + 1;

    packer_state_t            state_q, state_d;
    logic [FILL_W-1:0]        fill_q, fill_d;
    logic [15:0]              rem_q, rem_d;
    logic [8*BUF_BYTES-1:0]   buf_q, buf_d, buf_app;
    logic [FILL_W-1:0]        app_len;
    logic                     sop_pend_q, sop_pend_d;
    logic                     out_valid_q, out_valid_d;
    logic [OP_DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                     out_sop_q, out_sop_d;
    logic                     out_eop_q, out_eop_d;
    logic [2:0]               out_empty_q, out_empty_d;
    logic                     out_error_q, out_error_d;

    logic                     stalled, in_ready_c, accept, append, load, last_beat;
    logic [LEN_W-1:0]         len_c;
    logic [15:0]              cnt_eff;
    logic [OP_DATA_WIDTH-1:0] beat_c;

`ifdef MSG_PACKER_STATS_EN
    logic [15:0]              stat_q, stat_d;
`endif

    assign len_c   = (in_len > LEN_W'(MAX_MSG_SIZE)) ? LEN_W'(MAX_MSG_SIZE) : in_len;
    assign cnt_eff = (in_count == 16'd0) ? 16'd1 : in_count;

    msg_byte_aligner #(
        .BUF_BYTES (BUF_BYTES),
        .MSG_BYTES (MAX_MSG_SIZE),
        .FILL_W    (FILL_W),
        .LEN_W     (LEN_W)
    ) u_aligner (
        .buf_in     (buf_q),
        .fill       (fill_q),
        .with_count (state_q == IDLE),
        .count      (cnt_eff),
        .len        (len_c),
        .data       (in_data),
        .buf_out    (buf_app),
        .app_len    (app_len)
    );

    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        rem_d       = rem_q;
        buf_d       = buf_q;
        sop_pend_d  = sop_pend_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_empty_d = out_empty_q;

        stalled    = out_valid_q && !out_ready;
        in_ready_c = !reset && (state_q == IDLE || state_q == PACK) &&
                     (fill_q < FILL_W'(BYTES_PER_BEAT)) && !stalled;
        accept     = in_valid && in_ready_c;
        append     = accept && (state_q == PACK || in_sop);
        last_beat  = (state_q == DRAIN) && (fill_q <= FILL_W'(BYTES_PER_BEAT));
        // Accepts only happen below one beat of fill, so append and shift are exclusive.
        load       = !stalled && ((fill_q >= FILL_W'(BYTES_PER_BEAT)) ||
                                  (state_q == DRAIN && fill_q != '0));

        beat_c = '0;
        for (int k = 0; k < BYTES_PER_BEAT; k++) begin
            if (k < 32'(fill_q)) beat_c[8*(BYTES_PER_BEAT-1-k)+:8] = buf_q[8*k+:8];
        end

        out_error_d = accept && ((append && in_len > LEN_W'(MAX_MSG_SIZE)) ||
                                 (state_q == IDLE && (!in_sop || in_count == 16'd0)) ||
                                 (state_q == PACK && in_sop));

        if (append) begin
            fill_d = fill_q + app_len;
            buf_d  = buf_app;
        end else if (load) begin
            fill_d = last_beat ? '0 : fill_q - FILL_W'(BYTES_PER_BEAT);
            buf_d  = buf_q >> (8 * BYTES_PER_BEAT);
        end

        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = beat_c;
            out_sop_d   = sop_pend_q;
            out_eop_d   = last_beat;
            out_empty_d = last_beat ? 3'(BYTES_PER_BEAT - 32'(fill_q)) : 3'd0;
            sop_pend_d  = 1'b0;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_sop_d   = 1'b0;
            out_eop_d   = 1'b0;
            out_empty_d = 3'd0;
        end

        case (state_q)
            IDLE: begin
                if (accept && in_sop) begin
                    rem_d      = cnt_eff - 16'd1;
                    sop_pend_d = 1'b1;
                    state_d    = (cnt_eff == 16'd1) ? DRAIN : PACK;
                end
            end
            PACK: begin
                if (accept) begin
                    rem_d = (rem_q == 16'd0) ? 16'd0 : rem_q - 16'd1;
                    if (rem_q <= 16'd1) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_valid_q && out_eop_q && out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef MSG_PACKER_STATS_EN
    always_comb begin
        stat_d = stat_q;
        if (out_valid_q && out_ready) begin
            stat_d = (out_sop_q ? 16'd0 : stat_q) +
                     16'(BYTES_PER_BEAT - 32'(out_empty_q));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) stat_q <= 16'd0;
        else       stat_q <= stat_d;
    end

    assign stat_frame_bytes = stat_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            fill_q      <= '0;
            rem_q       <= 16'd0;
            sop_pend_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_empty_q <= 3'd0;
            out_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            rem_q       <= rem_d;
            sop_pend_q  <= sop_pend_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_empty_q <= out_empty_d;
            out_error_q <= out_error_d;
        end
    end

    // Staging bytes are qualified by fill, so they need no reset.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign in_ready           = in_ready_c;
    assign out_valid          = out_valid_q;
    assign out_data           = out_data_q;
    assign out_startofpayload = out_sop_q;
    assign out_endofpayload   = out_eop_q;
    assign out_empty          = out_empty_q;
    assign out_error          = out_error_q;

endmodule

// File: tb/tb_msg_packer.sv
// Directed bench for msg_packer: framing, boundaries, backpressure, errors, reset.
module tb_msg_packer;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, in_sop;
    logic [15:0]  in_count;
    logic [5:0]   in_len;
    logic [255:0] in_data;
    logic         out_valid, out_ready;
    logic [63:0]  out_data;
    logic         out_startofpayload, out_endofpayload;
    logic [2:0]   out_empty;
    logic         out_error;
`ifdef MSG_PACKER_STATS_EN
    logic [15:0]  stat_frame_bytes;
`endif

    msg_packer dut (
        .clk                (clk),
        .reset              (reset),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_sop             (in_sop),
        .in_count           (in_count),
        .in_len             (in_len),
        .in_data            (in_data),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_data           (out_data),
        .out_startofpayload (out_startofpayload),
        .out_endofpayload   (out_endofpayload),
        .out_empty          (out_empty),
        .out_error          (out_error)
`ifdef MSG_PACKER_STATS_EN
        ,.stat_frame_bytes  (stat_frame_bytes)
`endif
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    int          err_pulses = 0;
    logic [63:0] q_data[$];
    logic        q_sop[$];
    logic        q_eop[$];
    logic [2:0]  q_empty[$];
    logic [7:0]  xs[$];
    logic [255:0] d32;

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            q_data.push_back(out_data);
            q_sop.push_back(out_startofpayload);
            q_eop.push_back(out_endofpayload);
            q_empty.push_back(out_empty);
        end
        if (!reset && out_error) err_pulses++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        q_data.delete();
        q_sop.delete();
        q_eop.delete();
        q_empty.delete();
        xs.delete();
        err_pulses = 0;
    endtask

    task automatic send(input logic sop, input logic [15:0] cnt, input logic [5:0] len,
                        input logic [255:0] data);
        int w;
        @(negedge clk);
        in_valid = 1'b1;
        in_sop   = sop;
        in_count = cnt;
        in_len   = len;
        in_data  = data;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) check("send_timeout", 64'(in_ready), 64'(1'b1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int w;
        w = 0;
        while (!out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!out_valid) check({tag, "_valid_timeout"}, 64'(out_valid), 64'(1'b1));
    endtask

    task automatic wait_beats(input int n);
        int w;
        w = 0;
        while (q_data.size() < n && w < 200) begin
            @(posedge clk);
            w++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic m_hdr(input logic [15:0] c);
        xs.push_back(c[15:8]);
        xs.push_back(c[7:0]);
    endtask

    task automatic m_msg(input int len, input logic [255:0] d);
        int n;
        n = (len > 32) ? 32 : len;
        xs.push_back(8'(n >> 8));
        xs.push_back(8'(n));
        for (int k = 0; k < n; k++) xs.push_back(d[8*k+:8]);
    endtask

    task automatic check_beat(input string tag, input int i, input logic [63:0] d,
                              input logic s, input logic e, input logic [2:0] em);
        if (i >= q_data.size()) begin
            check({tag, "_present"}, 64'(q_data.size()), 64'(i + 1));
        end else begin
            check({tag, "_data"}, q_data[i], d);
            check({tag, "_sop"}, 64'(q_sop[i]), 64'(s));
            check({tag, "_eop"}, 64'(q_eop[i]), 64'(e));
            check({tag, "_empty"}, 64'(q_empty[i]), 64'(em));
        end
    endtask

    task automatic check_stream(input string tag);
        int          nb;
        int          idx;
        logic [63:0] e;
        nb = (xs.size() + 7) / 8;
        wait_beats(nb);
        check({tag, "_beats"}, 64'(q_data.size()), 64'(nb));
        for (int b = 0; b < nb && b < q_data.size(); b++) begin
            e = '0;
            for (int k = 0; k < 8; k++) begin
                idx = 8 * b + k;
                if (idx < xs.size()) e[8*(7-k)+:8] = xs[idx];
            end
            check_beat($sformatf("%s_b%0d", tag, b), b, e, (b == 0), (b == nb - 1),
                       (b == nb - 1) ? 3'(8 * nb - xs.size()) : 3'd0);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sop    = 1'b0;
        in_count  = 16'd0;
        in_len    = 6'd0;
        in_data   = '0;
        out_ready = 1'b1;
        for (int k = 0; k < 32; k++) d32[8*k+:8] = 8'(k);

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(out_valid), 64'(1'b0));
        check("rst_data", out_data, 64'h0);
        check("rst_sop_eop", 64'({out_startofpayload, out_endofpayload}), 64'(2'b00));
        check("rst_empty", 64'(out_empty), 64'(3'd0));
        check("rst_error", 64'(out_error), 64'(1'b0));
        check("rst_in_ready", 64'(in_ready), 64'(1'b0));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic two-message frame
        clear_mon();
        send(1'b1, 16'd2, 6'd3, 256'hCCBBAA);
        send(1'b0, 16'd0, 6'd5, 256'h1514131211);
        wait_beats(2);
        check("basic_beats", 64'(q_data.size()), 64'd2);
        check_beat("basic_b0", 0, 64'h0002_0003_AABB_CC00, 1'b1, 1'b0, 3'd0);
        check_beat("basic_b1", 1, 64'h0511_1213_1415_0000, 1'b0, 1'b1, 3'd2);
        check("basic_err", 64'(err_pulses), 64'd0);

        // Exact fit, with first-beat latency
        clear_mon();
        send(1'b1, 16'd1, 6'd4, 256'hEFBEADDE);
        check("lat_bubble", 64'(out_valid), 64'(1'b0));
        @(posedge clk);
        #1;
        check("lat_first", 64'(out_valid), 64'(1'b1));
        wait_beats(1);
        check("exact_beats", 64'(q_data.size()), 64'd1);
        check_beat("exact", 0, 64'h0001_0004_DEAD_BEEF, 1'b1, 1'b1, 3'd0);

        // Maximum-size message
        clear_mon();
        m_hdr(16'd1);
        m_msg(32, d32);
        send(1'b1, 16'd1, 6'd32, d32);
        check_stream("max");
        check_beat("max_b4", 4, 64'h1C1D_1E1F_0000_0000, 1'b0, 1'b1, 3'd4);

        // Oversized length clamps to 32 bytes
        clear_mon();
        m_hdr(16'd1);
        m_msg(40, d32);
        send(1'b1, 16'd1, 6'd40, d32);
        check_stream("clamp");
        check_beat("clamp_b0", 0, 64'h0001_0020_0001_0203, 1'b1, 1'b0, 3'd0);
        check("clamp_err", 64'(err_pulses), 64'd1);

        // Backpressure mid-frame
        clear_mon();
        m_hdr(16'd2);
        m_msg(32, d32);
        m_msg(3, 256'hCCBBAA);
        out_ready = 1'b0;
        send(1'b1, 16'd2, 6'd32, d32);
        @(negedge clk);
        wait_valid("bp");
        begin
            logic [63:0] held;
            held = out_data;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                check($sformatf("bp_hold%0d", c), out_data, held);
                check($sformatf("bp_rdy%0d", c), 64'(in_ready), 64'(1'b0));
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(1'b0, 16'd0, 6'd3, 256'hCCBBAA);
        check_stream("bp");
        check("bp_err", 64'(err_pulses), 64'd0);

        // Message in IDLE without sop is dropped
        clear_mon();
        send(1'b0, 16'd0, 6'd3, 256'hCCBBAA);
        repeat (10) @(posedge clk);
        #1;
        check("nosop_beats", 64'(q_data.size()), 64'd0);
        check("nosop_err", 64'(err_pulses), 64'd1);
        check("nosop_ready", 64'(in_ready), 64'(1'b1));

        // Zero-length message
        clear_mon();
        m_hdr(16'd2);
        m_msg(0, '0);
        m_msg(2, 256'h2211);
        send(1'b1, 16'd2, 6'd0, '0);
        send(1'b0, 16'd0, 6'd2, 256'h2211);
        check_stream("len0");
        check_beat("len0_lit", 0, 64'h0002_0000_0002_1122, 1'b1, 1'b1, 3'd0);

        // Count of zero is treated as one
        clear_mon();
        send(1'b1, 16'd0, 6'd4, 256'hEFBEADDE);
        wait_beats(1);
        check("cnt0_beats", 64'(q_data.size()), 64'd1);
        check("cnt0_err", 64'(err_pulses), 64'd1);
        if (q_eop.size() > 0) check("cnt0_eop", 64'(q_eop[0]), 64'(1'b1));

        // Reset while draining with six bytes left
        clear_mon();
        out_ready = 1'b0;
        send(1'b1, 16'd2, 6'd3, 256'hCCBBAA);
        send(1'b0, 16'd0, 6'd5, 256'h1514131211);
        @(negedge clk);
        wait_valid("rstd");
        #2;
        reset = 1'b1;
        #1;
        check("rstd_valid", 64'(out_valid), 64'(1'b0));
        check("rstd_sop", 64'(out_startofpayload), 64'(1'b0));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        clear_mon();
        m_hdr(16'd1);
        m_msg(2, 256'h6655);
        send(1'b1, 16'd1, 6'd2, 256'h6655);
        check_stream("post_rst");
        check_beat("post_rst_lit", 0, 64'h0001_0002_5566_0000, 1'b1, 1'b1, 3'd2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/msg_packer.md
Name: msg_packer

Overview:
Transmit-side counterpart of the stream message parser. It accepts whole messages on a wide bus (up to MAX_MSG_SIZE bytes, with a byte length) and serialises them into a narrow payload stream with a valid/ready handshake. The framing is: a 2-byte message count, then for each message a 2-byte length followed by its data. Sits between the message source and the 64-bit link interface that feeds the parser on the far end.

Parameters:
OP_DATA_WIDTH, 64, output stream width in bits (8 bytes per beat).
IN_DATA_WIDTH, 256, input message bus width in bits.
MAX_MSG_SIZE, 32, maximum message length in bytes (IN_DATA_WIDTH/8).
MSG_COUNT_LEN, 2, count header size in bytes.
MSG_LENGTH_LEN, 2, per-message length prefix size in bytes.
BUF_BYTES, 48, staging buffer depth in bytes; must be at least 8+2+2+MAX_MSG_SIZE.

Ports:
clk  in  1  clock.
reset  in  1  asynchronous, active-high reset.
in_valid  in  1  message present.
in_ready  out  1  message accepted when in_valid && in_ready.
in_sop  in  1  first message of a frame; qualifies in_count.
in_count  in  16  messages in the frame; sampled only with in_sop.
in_len  in  $clog2(MAX_MSG_SIZE)+1  message length in bytes, 0..MAX_MSG_SIZE.
in_data  in  IN_DATA_WIDTH  message byte k = in_data[8*k+:8].
out_valid  out  1  beat present.
out_ready  in  1  sink accepts beat.
out_data  out  OP_DATA_WIDTH  stream byte k = out_data[8*(7-k)+:8].
out_startofpayload  out  1  first beat of frame.
out_endofpayload  out  1  last beat of frame.
out_empty  out  3  unused trailing bytes in the eop beat; 0 on other beats.
out_error  out  1  one-cycle pulse on a protocol violation.

Behaviour:
- Reset: all outputs 0, buffer fill 0, state IDLE. Reset mid-frame discards the buffer and frame; out_valid drops asynchronously.
- Buffer: byte-addressed, fill counter 0..BUF_BYTES. Multi-byte fields are big-endian (MSB byte first).
- in_ready = (state==IDLE or PACK) && fill<8 && !(out_valid && !out_ready).
- An accept and a buffer shift never occur in the same cycle. The accept cycle costs one bubble.
- Accept appends at offset fill: [count hi, count lo] if in_sop, then [len hi, len lo], then in_len data bytes. fill += in_len + 2 (+2 with in_sop).
- Emit: load the output register from buffer bytes 0..7 when fill>=8 and the register is empty or handshaking, then shift the buffer by 8. Output data is held stable while out_valid && !out_ready.
- Latency: first beat is valid one cycle after the accepting edge.
- States:
  - IDLE: accept only with in_sop. Load remaining = in_count, then decrement. Go to PACK, or to DRAIN if remaining reaches 0.
  - PACK: accept messages and decrement remaining. The accept that makes remaining 0 moves to DRAIN.
  - DRAIN: in_ready=0. Emit full beats. When 0<fill<=8, emit the final beat with eop=1, out_empty=8-fill, and pad bytes 0.
  - After the eop beat handshakes, return to IDLE.
- out_startofpayload=1 on the first beat after the sop accept only.
- Boundary cases:
  - in_len=0 is legal; only the 0x0000 prefix is emitted.
  - in_len>MAX_MSG_SIZE: clamp to MAX_MSG_SIZE, pulse out_error.
  - in_count=0 with in_sop: treat as 1, pulse out_error.
  - In IDLE, in_valid without in_sop: consume (in_ready=1), drop, pulse out_error.
  - In PACK, in_sop=1: ignore sop and in_count, pack as a normal message, pulse out_error.
  - Remaining count is 16 bits and never wraps; it stops at 0.

Optional Feature:
MSG_PACKER_STATS_EN: when defined, adds output stat_frame_bytes[15:0]. It counts bytes emitted in the current frame, including headers, excluding pad. It clears at each sop beat and is held after eop until the next sop. When not defined, the port and its counter are absent.

Decomposition:
- Shared package parser_pkg:
  - constants MSG_COUNT_LEN, MSG_LENGTH_LEN, BYTES_PER_BEAT=8, MAX_MSG_SIZE;
  - state enum packer_state_t {IDLE, PACK, DRAIN};
  - byte typedef byte_t.
- One combinational sub-module, msg_byte_aligner. It builds the append vector (optional count, length prefix, data) and places it at offset fill into the buffer's next-state value.

Test Plan:
- Basic frame: sop, count=2, then len=3 data AA BB CC, then len=5 data 11..15. Required output:
  - beat0 64'h0002_0003_AABB_CC00 with sop=1;
  - beat1 64'h0511_1213_1415_0000 with eop=1, empty=2.
- Exact fit: count=1, len=4 data DEADBEEF -> single beat 64'h0001_0004_DEAD_BEEF with sop=1, eop=1, empty=0.
- Maximum message: count=1, len=32 data 00..1F -> 5 beats. Beat4 = 64'h1C1D_1E1F_0000_0000, eop=1, empty=4.
- Backpressure: out_ready=0 for 5 cycles mid-frame -> out_data stable, in_ready=0, no byte loss. The frame matches the unstalled run byte-for-byte.
- Errors:
  - len=40 -> out_error pulse, 32 bytes packed, length field 0x0020;
  - IDLE message without sop -> out_error, no output beat.
- Reset in DRAIN with fill=6 -> out_valid=0 immediately. The next frame starts with sop and count header and carries no residue.
